serial_rx_ctrl: RTL and testbench
=================================

// Module: serial_rx_ctrl
// PURPOSE
//  Parametrised receive controller for the serial full-duplex link. On a start request it
//  pulses latch_flag to the remote transmitter, generates sck_rx at a programmable rate and
//  shifts in DATA_WIDTH bits from data_rx. Each word is presented on a valid/ready output
//  register. Sits between the link pins and the host-side receive datapath.
// PARAMETERS
//  DATA_WIDTH  8  bits per frame, 2..64; any value, not restricted to powers of 2
//  SCK_DIV     1  clk cycles per sck_rx half-period (phase length D), >=1
//  LSB_FIRST   1  1: first received bit lands in rx_data[0]; 0: it lands in rx_data[MSB]
// PORTS
//  clk         in   1  system clock; all logic on posedge
//  rst         in   1  synchronous reset, active-high
//  start       in   1  frame request; sampled only in IDLE, ignored otherwise
//  data_rx     in   1  serial data from the remote transmitter
//  sck_rx      out  1  shift clock to the remote transmitter
//  latch_flag  out  1  load strobe to the remote transmitter
//  busy        out  1  high in every state except IDLE
//  rx_data     out  DATA_WIDTH  received word; stable while rx_valid=1
//  rx_valid    out  1  word available; held until rx_ready
//  rx_ready    in   1  consumer accepts the word when rx_valid&&rx_ready
//  overrun     out  1  1-cycle pulse: a frame completed while rx_valid=1 and not accepted
//  parity_err  out  1  only with RX_PARITY_EN; qualified by rx_valid
// BEHAVIOUR
//  Reset: all outputs 0, rx_data=0, state IDLE, counters cleared. Reset wins over every
//   event, including mid-frame; the partial frame is discarded and no overrun is raised.
//  States, with dwell times:
//   IDLE -> LOAD on start.
//   LOAD     latch=1 sck=0 D cyc
//   LOAD_HI  latch=1 sck=1 D cyc
//   LOAD_LO  latch=1 sck=0 D cyc
//   SAMPLE   latch=0 sck=0 1 cyc: shift in data_rx, bit_cnt++
//   SAMPLE exits to DONE when bit_cnt==DATA_WIDTH, else to SHIFT_HI.
//   SHIFT_HI sck=1 D cyc -> SHIFT_LO sck=0 D cyc -> SAMPLE
//   DONE  1 cyc -> IDLE. The output register is written at the DONE edge.
//  sck_rx and latch_flag are registered outputs, glitch-free. Phase timing uses a
//   counter of width clog2(SCK_DIV+1).
//  Shifting: LSB_FIRST=1 shifts right with data_rx entering the MSB; LSB_FIRST=0 shifts
//   left with data_rx entering the LSB.
//  Latency: rx_valid rises 3D + W + 2D(W-1) + 1 cycles after the cycle in which start is
//   sampled (W=DATA_WIDTH). For W=8, D=1 this is 26 cycles.
//  Output register:
//   DONE with rx_valid=0, or with rx_valid&&rx_ready in the same cycle: load rx_data and
//    set rx_valid=1.
//   DONE with rx_valid=1 and rx_ready=0: the new word is dropped, rx_data is kept and
//    overrun pulses for 1 cycle.
//   rx_valid&&rx_ready outside DONE: rx_valid clears next cycle.
//  The next frame may start right after DONE; the handshake never blocks the FSM.
// CONFIGURATION
//  RX_PARITY_EN defined:
//   - One extra SHIFT_HI/SHIFT_LO/SAMPLE round after the data bits captures an even-parity
//     bit; latency grows by 2D+1.
//   - parity_err = XOR of the data bits and the parity bit, registered with rx_data.
//  RX_PARITY_EN undefined: no parity_err port, no extra round.
// STRUCTURE
//  serial_defs.vh, shared with the TX side: state localparams (3-bit encoding), a default
//   DATA_WIDTH, and a clog2 function.
//  Sub-module sck_phase_timer: loadable down-counter; asserts phase_done after SCK_DIV
//   cycles. It is reused by the TX controller.
// TESTING
//  1. W=8, D=1, LSB_FIRST=1, rx_ready=1; data_rx bits 1,0,1,1,0,0,1,0 (first bit first)
//     -> rx_data=8'h4D, rx_valid at cycle 26 lasting 1 cycle, 7 sck pulses after latch.
//  2. Same stream with LSB_FIRST=0 -> rx_data=8'hB2.
//  3. rx_ready=0; frame 0x4D, then frame 0xFF -> overrun pulses 1 cycle at the 2nd DONE;
//     rx_data stays 8'h4D until rx_ready=1.
//  4. rst=1 for one cycle during SHIFT_HI -> next cycle sck_rx=0, latch_flag=0, busy=0,
//     rx_valid=0; a new start then gives a correct 0x4D.
//  5. D=3, W=5: start pulsed while busy -> ignored; sck_rx high/low = 3 cycles each;
//     rx_valid at cycle 3*3+5+2*3*4+1=39.
//  6. RX_PARITY_EN, W=8: 0x4D with parity bit 0 -> parity_err=0; with parity bit 1 ->
//     parity_err=1; rx_valid at cycle 29 (D=1).

Source files
------------

// File: rtl/serial_rx_ctrl_pkg.sv
// Shared definitions for the serial link controllers: FSM state encoding,
// default frame width and a constant clog2 helper.
package serial_rx_ctrl_pkg;

    localparam int DEF_DATA_WIDTH = 8;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_LOAD     = 3'd1,
        ST_LOAD_HI  = 3'd2,
        ST_LOAD_LO  = 3'd3,
        ST_SAMPLE   = 3'd4,
        ST_SHIFT_HI = 3'd5,
        ST_SHIFT_LO = 3'd6,
        ST_DONE     = 3'd7
    } state_t;

    function automatic int clog2(input int value);
        int r;
        int v;
        r = 0;
        v = value - 1;
        while (v > 0) begin
            r++;
            v = v >> 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/sck_phase_timer.sv
// Loadable down-counter that times one sck phase: phase_done is high in the
// SCK_DIV-th cycle after a load. Shared with the transmit controller.
module sck_phase_timer
    import serial_rx_ctrl_pkg::*;
#(
    parameter int SCK_DIV = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    output logic phase_done
);

    localparam int CW = clog2(SCK_DIV + 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= CW'(SCK_DIV - 1);
        end else if (cnt != '0) begin
            cnt <= cnt - CW'(1);
        end
    end

    assign phase_done = (cnt == '0);

endmodule

// File: rtl/serial_rx_ctrl.sv
// Receive controller for the serial full-duplex link: latch strobe, sck_rx
// generation, bit capture and a valid/ready output register. Optional RX_PARITY_EN.
module serial_rx_ctrl
    import serial_rx_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int SCK_DIV    = 1,
    parameter bit LSB_FIRST  = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  data_rx,
    output logic                  sck_rx,
    output logic                  latch_flag,
    output logic                  busy,
    output logic [DATA_WIDTH-1:0] rx_data,
    output logic                  rx_valid,
    input  logic                  rx_ready,
    output logic                  overrun
`ifdef RX_PARITY_EN
   ,output logic                  parity_err
`endif
);

`ifdef RX_PARITY_EN
    localparam int PARITY_BITS = 1;
`else
    localparam int PARITY_BITS = 0;
`endif
    localparam int FRAME_BITS = DATA_WIDTH + PARITY_BITS;
    localparam int BW         = clog2(FRAME_BITS + 1);
    localparam logic [BW-1:0] LAST_BIT  = BW'(FRAME_BITS - 1);
    localparam logic [BW-1:0] DATA_BITS = BW'(DATA_WIDTH);

    state_t                state_q, state_d;
    logic                  phase_done;
    logic                  timer_load;
    logic [BW-1:0]         bit_cnt;
    logic [DATA_WIDTH-1:0] shreg;
`ifdef RX_PARITY_EN
    logic                  par_acc;
`endif

    // Every state change restarts the phase timer; untimed states ignore it.
    assign timer_load = (state_d != state_q);
    assign busy       = (state_q != ST_IDLE);

    sck_phase_timer #(.SCK_DIV(SCK_DIV)) u_timer (
        .clk        (clk),
        .rst        (rst),
        .load       (timer_load),
        .phase_done (phase_done)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:     if (start)      state_d = ST_LOAD;
            ST_LOAD:     if (phase_done) state_d = ST_LOAD_HI;
            ST_LOAD_HI:  if (phase_done) state_d = ST_LOAD_LO;
            ST_LOAD_LO:  if (phase_done) state_d = ST_SAMPLE;
            ST_SAMPLE:   state_d = (bit_cnt == LAST_BIT) ? ST_DONE : ST_SHIFT_HI;
            ST_SHIFT_HI: if (phase_done) state_d = ST_SHIFT_LO;
            ST_SHIFT_LO: if (phase_done) state_d = ST_SAMPLE;
            ST_DONE:     state_d = ST_IDLE;
            default:     state_d = ST_IDLE;
        endcase
    end

    // Pin outputs decoded from the next state so they are flop-driven yet state-aligned.
    always_ff @(posedge clk) begin
        if (rst) begin
            sck_rx     <= 1'b0;
            latch_flag <= 1'b0;
        end else begin
            sck_rx     <= (state_d == ST_LOAD_HI) || (state_d == ST_SHIFT_HI);
            latch_flag <= (state_d == ST_LOAD) || (state_d == ST_LOAD_HI) ||
                          (state_d == ST_LOAD_LO);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bit_cnt <= '0;
        end else if (state_q == ST_IDLE) begin
            bit_cnt <= '0;
        end else if (state_q == ST_SAMPLE) begin
            bit_cnt <= bit_cnt + BW'(1);
        end
    end

    // The parity bit, when present, only feeds the accumulator, never the word.
    always_ff @(posedge clk) begin
        if (state_q == ST_SAMPLE && bit_cnt < DATA_BITS) begin
            if (LSB_FIRST) begin
                shreg <= {data_rx, shreg[DATA_WIDTH-1:1]};
            end else begin
                shreg <= {shreg[DATA_WIDTH-2:0], data_rx};
            end
        end
    end

`ifdef RX_PARITY_EN
    always_ff @(posedge clk) begin
        if (state_q == ST_IDLE) begin
            par_acc <= 1'b0;
        end else if (state_q == ST_SAMPLE) begin
            par_acc <= par_acc ^ data_rx;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_valid <= 1'b0;
            rx_data  <= '0;
            overrun  <= 1'b0;
`ifdef RX_PARITY_EN
            parity_err <= 1'b0;
`endif
        end else begin
            overrun <= 1'b0;
            if (state_q == ST_DONE) begin
                if (!rx_valid || rx_ready) begin
                    rx_valid <= 1'b1;
                    rx_data  <= shreg;
`ifdef RX_PARITY_EN
                    parity_err <= par_acc;
`endif
                end else begin
                    overrun <= 1'b1;
                end
            end else if (rx_valid && rx_ready) begin
                rx_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_serial_rx_ctrl.sv
// Bench for serial_rx_ctrl: three configurations (W8/D1 LSB-first, W8/D1 MSB-first,
// W5/D3) checked every cycle against a timing-formula model, plus literal expectations.
module tb_serial_rx_ctrl;

    localparam int NI = 3;
`ifdef RX_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       start   [NI];
    logic       ready   [NI];
    logic       data_rx [NI];
    logic       sck     [NI];
    logic       latch   [NI];
    logic       busy    [NI];
    logic       valid   [NI];
    logic       ovr     [NI];
    logic [7:0] rd0, rd1;
    logic [4:0] rd2;
`ifdef RX_PARITY_EN
    logic       perr    [NI];
`endif

    always #5 clk = ~clk;

    serial_rx_ctrl #(.DATA_WIDTH(8), .SCK_DIV(1), .LSB_FIRST(1'b1)) u0 (
        .clk(clk), .rst(rst), .start(start[0]), .data_rx(data_rx[0]), .sck_rx(sck[0]),
        .latch_flag(latch[0]), .busy(busy[0]), .rx_data(rd0), .rx_valid(valid[0]),
        .rx_ready(ready[0]), .overrun(ovr[0])
`ifdef RX_PARITY_EN
       ,.parity_err(perr[0])
`endif
    );

    serial_rx_ctrl #(.DATA_WIDTH(8), .SCK_DIV(1), .LSB_FIRST(1'b0)) u1 (
        .clk(clk), .rst(rst), .start(start[1]), .data_rx(data_rx[1]), .sck_rx(sck[1]),
        .latch_flag(latch[1]), .busy(busy[1]), .rx_data(rd1), .rx_valid(valid[1]),
        .rx_ready(ready[1]), .overrun(ovr[1])
`ifdef RX_PARITY_EN
       ,.parity_err(perr[1])
`endif
    );

    serial_rx_ctrl #(.DATA_WIDTH(5), .SCK_DIV(3), .LSB_FIRST(1'b1)) u2 (
        .clk(clk), .rst(rst), .start(start[2]), .data_rx(data_rx[2]), .sck_rx(sck[2]),
        .latch_flag(latch[2]), .busy(busy[2]), .rx_data(rd2), .rx_valid(valid[2]),
        .rx_ready(ready[2]), .overrun(ovr[2])
`ifdef RX_PARITY_EN
       ,.parity_err(perr[2])
`endif
    );

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic int wof(input int i);
        return (i == 2) ? 5 : 8;
    endfunction
    function automatic int dof(input int i);
        return (i == 2) ? 3 : 1;
    endfunction
    function automatic bit lsbof(input int i);
        return (i == 1) ? 1'b0 : 1'b1;
    endfunction

    // Cycles from the start-sampling edge to the edge that raises rx_valid.
    function automatic int lat(input int i);
        int d, nb;
        d  = dof(i);
        nb = wof(i) + PAR;
        return 3*d + nb + 2*d*(nb-1) + 1;
    endfunction

    // Expected pin levels c cycles into a frame, from the phase dwell table.
    function automatic logic exp_sck(input int i, input int c);
        int d, nb, o;
        d  = dof(i);
        nb = wof(i) + PAR;
        if (c >= d && c < 2*d) return 1'b1;
        if (c >= 3*d + 1) begin
            o = c - 3*d - 1;
            return ((o % (2*d+1)) < d) && ((o / (2*d+1)) < nb - 1);
        end
        return 1'b0;
    endfunction
    function automatic logic exp_latch(input int i, input int c);
        return c < 3*dof(i);
    endfunction

    // Word assembled from the serial bits w[0] (first sent) .. w[W-1].
    function automatic logic [7:0] exp_word(input int i, input logic [8:0] w);
        logic [7:0] d;
        d = '0;
        for (int k = 0; k < wof(i); k++) begin
            if (lsbof(i)) d[k] = w[k];
            else          d[wof(i)-1-k] = w[k];
        end
        return d;
    endfunction
    function automatic logic exp_par(input int i, input logic [8:0] w);
        logic p;
        p = 1'b0;
        for (int k = 0; k < wof(i) + PAR; k++) p = p ^ w[k];
        return p;
    endfunction

    function automatic logic [7:0] rd(input int i);
        if (i == 0) return rd0;
        if (i == 1) return rd1;
        return {3'b000, rd2};
    endfunction

    // Remote transmitter: first bit on latch, next bit on each sck rise after latch.
    logic [8:0] txw [NI];
    int         idx [NI];
    logic       tx_psck [NI];
    logic       tx_platch [NI];

    initial begin
        for (int i = 0; i < NI; i++) begin
            idx[i] = 0; tx_psck[i] = 1'b0; tx_platch[i] = 1'b0; data_rx[i] = 1'b0;
        end
    end

    always @(posedge clk) begin
        #1;
        for (int i = 0; i < NI; i++) begin
            if (latch[i] === 1'b1 && tx_platch[i] !== 1'b1) idx[i] = 0;
            else if (sck[i] === 1'b1 && tx_psck[i] !== 1'b1 && latch[i] === 1'b0 && idx[i] < 8)
                idx[i] = idx[i] + 1;
            tx_psck[i]   = sck[i];
            tx_platch[i] = latch[i];
            data_rx[i]   = txw[i][idx[i]];
        end
    end

    // Behavioural model, advanced on each clock edge from the sampled inputs.
    int         cycle = 0;
    int         m_cyc [NI];
    int         start_cyc [NI];
    bit         m_busy [NI], m_valid [NI], m_ovr [NI], m_perr [NI], m_ppend [NI];
    logic [7:0] m_data [NI], m_pend [NI];
    bit         done;

    initial begin
        for (int i = 0; i < NI; i++) begin
            m_cyc[i] = 0; start_cyc[i] = 0; m_busy[i] = 0; m_valid[i] = 0; m_ovr[i] = 0;
            m_perr[i] = 0; m_ppend[i] = 0; m_data[i] = '0; m_pend[i] = '0;
        end
    end

    always @(posedge clk) begin
        cycle++;
        for (int i = 0; i < NI; i++) begin
            done     = 1'b0;
            m_ovr[i] = 1'b0;
            if (rst) begin
                m_busy[i] = 0; m_valid[i] = 0; m_data[i] = '0; m_perr[i] = 0;
            end else begin
                if (m_busy[i]) begin
                    m_cyc[i]++;
                    if (m_cyc[i] == lat(i)) begin
                        done = 1'b1;
                        m_busy[i] = 0;
                    end
                end else if (start[i]) begin
                    m_busy[i]    = 1;
                    m_cyc[i]     = 0;
                    start_cyc[i] = cycle;
                    m_pend[i]    = exp_word(i, txw[i]);
                    m_ppend[i]   = exp_par(i, txw[i]);
                end
                if (done) begin
                    if (!m_valid[i] || ready[i]) begin
                        m_valid[i] = 1;
                        m_data[i]  = m_pend[i];
                        m_perr[i]  = m_ppend[i];
                    end else begin
                        m_ovr[i] = 1;
                    end
                end else if (m_valid[i] && ready[i]) begin
                    m_valid[i] = 0;
                end
            end
        end
    end

    // Per-cycle compare plus event tracking for the literal checks.
    bit         chk_en = 1'b0;
    int         rise_lat [NI], sckp [NI], shigh [NI], vcnt [NI], ovr_cnt [NI];
    logic [7:0] cap_data [NI];
    logic       cap_perr [NI];
    logic       pv [NI], psck [NI];

    initial begin
        for (int i = 0; i < NI; i++) begin
            rise_lat[i] = -1; sckp[i] = 0; shigh[i] = 0; vcnt[i] = 0; ovr_cnt[i] = 0;
            cap_data[i] = '0; cap_perr[i] = 1'b0; pv[i] = 1'b0; psck[i] = 1'b0;
        end
    end

    always @(negedge clk) begin
        for (int i = 0; i < NI; i++) begin
            if (chk_en) begin
                chk($sformatf("u%0d.valid", i), valid[i], m_valid[i]);
                chk($sformatf("u%0d.busy", i), busy[i], m_busy[i]);
                chk($sformatf("u%0d.overrun", i), ovr[i], m_ovr[i]);
                chk($sformatf("u%0d.sck_rx", i), sck[i],
                    m_busy[i] ? exp_sck(i, m_cyc[i]) : 1'b0);
                chk($sformatf("u%0d.latch_flag", i), latch[i],
                    m_busy[i] ? exp_latch(i, m_cyc[i]) : 1'b0);
                if (m_valid[i]) begin
                    chk($sformatf("u%0d.rx_data", i), rd(i), m_data[i]);
`ifdef RX_PARITY_EN
                    chk($sformatf("u%0d.parity_err", i), perr[i], m_perr[i]);
`endif
                end
            end
            if (valid[i] === 1'b1 && pv[i] !== 1'b1) begin
                rise_lat[i] = cycle - start_cyc[i];
                cap_data[i] = rd(i);
`ifdef RX_PARITY_EN
                cap_perr[i] = perr[i];
`endif
            end
            if (sck[i] === 1'b1 && psck[i] !== 1'b1 && latch[i] === 1'b0) sckp[i]++;
            if (sck[i] === 1'b1)   shigh[i]++;
            if (valid[i] === 1'b1) vcnt[i]++;
            if (ovr[i] === 1'b1)   ovr_cnt[i]++;
            pv[i]   = valid[i];
            psck[i] = sck[i];
        end
    end

    task automatic frame(input int i, input logic [8:0] w, input logic rdy);
        txw[i]      = w;
        ready[i]    = rdy;
        rise_lat[i] = -1;
        sckp[i]     = 0;
        shigh[i]    = 0;
        vcnt[i]     = 0;
        ovr_cnt[i]  = 0;
        start[i]    = 1'b1;
        @(negedge clk);
        start[i]    = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "bench timeout");
    end

    bit found;

    initial begin
        rst = 1'b1;
        for (int i = 0; i < NI; i++) begin
            start[i] = 1'b0; ready[i] = 1'b1; txw[i] = '0;
        end
        repeat (2) @(negedge clk);
        chk("reset.sck_rx", sck[0], 1'b0);
        chk("reset.latch_flag", latch[0], 1'b0);
        chk("reset.busy", busy[0], 1'b0);
        chk("reset.rx_valid", valid[0], 1'b0);
        chk("reset.rx_data", rd0, 8'h00);
        chk("reset.overrun", ovr[0], 1'b0);
        rst    = 1'b0;
        chk_en = 1'b1;

        // Stream 1,0,1,1,0,0,1,0 first bit first, LSB-first capture.
        frame(0, 9'h04D, 1'b1);
        repeat (lat(0) + 3) @(negedge clk);
        chk("t1.latency", rise_lat[0], (PAR != 0) ? 29 : 26);
        chk("t1.rx_data", cap_data[0], 8'h4D);
        chk("t1.valid_cycles", vcnt[0], 1);
        chk("t1.sck_pulses", sckp[0], (PAR != 0) ? 8 : 7);

        // Same stream, MSB-first capture.
        frame(1, 9'h04D, 1'b1);
        repeat (lat(1) + 3) @(negedge clk);
        chk("t2.rx_data", cap_data[1], 8'hB2);
        chk("t2.latency", rise_lat[1], (PAR != 0) ? 29 : 26);

        // Consumer stalled: second word is dropped with an overrun pulse.
        frame(0, 9'h04D, 1'b0);
        repeat (lat(0) + 3) @(negedge clk);
        chk("t3.first_word", cap_data[0], 8'h4D);
        frame(0, 9'h0FF, 1'b0);
        repeat (lat(0) + 3) @(negedge clk);
        chk("t3.overrun_pulses", ovr_cnt[0], 1);
        chk("t3.held_data", rd0, 8'h4D);
        chk("t3.held_valid", valid[0], 1'b1);
        ready[0] = 1'b1;
        @(negedge clk);
        chk("t3.valid_cleared", valid[0], 1'b0);

        // Reset in the middle of a shift phase.
        frame(0, 9'h04D, 1'b1);
        found = 1'b0;
        for (int k = 0; k < 30 && !found; k++) begin
            if (sck[0] === 1'b1 && latch[0] === 1'b0) found = 1'b1;
            else @(negedge clk);
        end
        chk("t4.reached_shift_hi", found, 1'b1);
        rst = 1'b1;
        @(negedge clk);
        chk("t4.sck_rx", sck[0], 1'b0);
        chk("t4.latch_flag", latch[0], 1'b0);
        chk("t4.busy", busy[0], 1'b0);
        chk("t4.rx_valid", valid[0], 1'b0);
        rst = 1'b0;
        @(negedge clk);
        frame(0, 9'h04D, 1'b1);
        repeat (lat(0) + 3) @(negedge clk);
        chk("t4.rx_data", cap_data[0], 8'h4D);
        chk("t4.latency", rise_lat[0], (PAR != 0) ? 29 : 26);
        chk("t4.overrun_pulses", ovr_cnt[0], 0);

        // W=5, D=3: a start while busy is ignored.
        frame(2, 9'h016, 1'b1);
        repeat (10) @(negedge clk);
        start[2] = 1'b1;
        @(negedge clk);
        start[2] = 1'b0;
        repeat (lat(2)) @(negedge clk);
        chk("t5.latency", rise_lat[2], (PAR != 0) ? 46 : 39);
        chk("t5.rx_data", cap_data[2], 8'h16);
        chk("t5.sck_high_cycles", shigh[2], (PAR != 0) ? 18 : 15);
        chk("t5.busy_after", busy[2], 1'b0);
        chk("t5.valid_cycles", vcnt[2], 1);

`ifdef RX_PARITY_EN
        frame(0, 9'h04D, 1'b1);
        repeat (lat(0) + 3) @(negedge clk);
        chk("t6.parity_ok", cap_perr[0], 1'b0);
        chk("t6.rx_data", cap_data[0], 8'h4D);
        chk("t6.latency", rise_lat[0], 29);
        frame(0, 9'h14D, 1'b1);
        repeat (lat(0) + 3) @(negedge clk);
        chk("t6.parity_bad", cap_perr[0], 1'b1);
        chk("t6.rx_data_bad", cap_data[0], 8'h4D);
`endif

        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
